// File: rtl/rep5_tx_if.sv
// Word-offer handshake into the five-lane redundant serial transmitter.
// The producer drives data and fault mask; the transmitter returns ready.
interface rep5_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [4:0]       inj_mask;

  modport master (
    output in_valid,
    output in_data,
    output inj_mask,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  inj_mask,
    output in_ready
  );
endinterface

// File: rtl/rep5_tx.sv
// Five-lane redundant UART-style transmitter for a 5-way majority receiver.
// Frame: start, WIDTH data bits MSB-first, stop; each lane XORed with a mask.
module rep5_tx #(
  parameter int WIDTH      = 8,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  rep5_tx_if.slave   src,
  output logic       pa,
  output logic       pb,
  output logic       pc,
  output logic       pd,
  output logic       pe,
  output logic       tx_active,
  output logic       tx_last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_d;
  logic [4:0]       mask;
  logic [4:0]       mask_d;
  logic [4:0]       lane;
  logic [4:0]       lane_d;
  logic             rdy;
  logic             rdy_d;
  logic             act_d;
  logic             last_d;
  logic             accept;

  assign accept       = src.in_valid & rdy;
  assign src.in_ready = rdy;
  assign {pe, pd, pc, pb, pa} = lane;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
    mask_d  = mask;
    lane_d  = lane;
    unique case (state)
      IDLE, STOP: begin
        if (accept) begin
          state_d = START;
          sh_d    = src.in_data;
          mask_d  = src.inj_mask;
          cnt_d   = '0;
          lane_d  = {5{~IDLE_LEVEL}} ^ src.inj_mask;
        end else begin
          state_d = IDLE;
          lane_d  = {5{IDLE_LEVEL}};
        end
      end
      START: begin
        state_d = DATA;
        lane_d  = {5{sh[WIDTH-1]}} ^ mask;
        sh_d    = sh << 1;
        cnt_d   = CW'(1);
      end
      DATA: begin
        if (cnt == LAST) begin
          state_d = STOP;
          lane_d  = {5{IDLE_LEVEL}} ^ mask;
        end else begin
          lane_d = {5{sh[WIDTH-1]}} ^ mask;
          sh_d   = sh << 1;
          cnt_d  = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        lane_d  = {5{IDLE_LEVEL}};
      end
    endcase
  end

  // Flags are registered from the next state so they align with the lanes.
  always_comb begin
    rdy_d  = (state_d == IDLE) || (state_d == STOP);
    act_d  = (state_d != IDLE);
    last_d = (state_d == STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      mask      <= '0;
      lane      <= {5{IDLE_LEVEL}};
      rdy       <= 1'b0;
      tx_active <= 1'b0;
      tx_last   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sh        <= sh_d;
      mask      <= mask_d;
      lane      <= lane_d;
      rdy       <= rdy_d;
      tx_active <= act_d;
      tx_last   <= last_d;
    end
  end

endmodule

// File: tb/tb_rep5_tx.sv
// Directed bench for rep5_tx: default build plus WIDTH=1/32 idle-low builds.
// Lanes are sampled 1 time unit after each rising edge.
module tb_rep5_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  rep5_tx_if #(.WIDTH(8))  i0 ();
  rep5_tx_if #(.WIDTH(1))  i1 ();
  rep5_tx_if #(.WIDTH(32)) i2 ();

  logic pa0, pb0, pc0, pd0, pe0, act0, last0;
  logic pa1, pb1, pc1, pd1, pe1, act1, last1;
  logic pa2, pb2, pc2, pd2, pe2, act2, last2;
  logic [4:0] l0, l1, l2;
  assign l0 = {pe0, pd0, pc0, pb0, pa0};
  assign l1 = {pe1, pd1, pc1, pb1, pa1};
  assign l2 = {pe2, pd2, pc2, pb2, pa2};

  rep5_tx #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .src(i0.slave),
    .pa(pa0), .pb(pb0), .pc(pc0), .pd(pd0), .pe(pe0),
    .tx_active(act0), .tx_last(last0)
  );

  rep5_tx #(.WIDTH(1), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .src(i1.slave),
    .pa(pa1), .pb(pb1), .pc(pc1), .pd(pd1), .pe(pe1),
    .tx_active(act1), .tx_last(last1)
  );

  rep5_tx #(.WIDTH(32), .IDLE_LEVEL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .src(i2.slave),
    .pa(pa2), .pb(pb2), .pc(pc2), .pd(pd2), .pe(pe2),
    .tx_active(act2), .tx_last(last2)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic maj5(input logic [4:0] v);
    return $countones(v) >= 3;
  endfunction

  // Expected 8-bit frame bit at cycle c, idle level 1.
  function automatic logic fb8(input logic [7:0] d, input int c);
    if (c == 0) return 1'b0;
    if (c <= 8) return d[8-c];
    return 1'b1;
  endfunction

  function automatic logic fb32(input logic [31:0] d, input int c);
    if (c == 0) return 1'b1;
    if (c <= 32) return d[32-c];
    return 1'b0;
  endfunction

  task automatic send8(input logic [7:0] d, input logic [4:0] m);
    i0.in_valid = 1'b1;
    i0.in_data  = d;
    i0.inj_mask = m;
    tick();
    i0.in_valid = 1'b0;
  endtask

  task automatic chk8(input string tag, input int c,
                      input logic b, input logic [4:0] m);
    check($sformatf("%s lanes c%0d", tag, c), 64'(l0), 64'({5{b}} ^ m));
    check($sformatf("%s maj c%0d", tag, c), 64'(maj5(l0)), 64'(b));
    check($sformatf("%s act c%0d", tag, c), 64'(act0), 64'd1);
    check($sformatf("%s last c%0d", tag, c), 64'(last0), 64'(c == 9));
  endtask

  task automatic chk_idle8(input string tag);
    check({tag, " idle lanes"}, 64'(l0), 64'h1f);
    check({tag, " idle act"}, 64'(act0), 64'd0);
    check({tag, " idle rdy"}, 64'(i0.in_ready), 64'd1);
  endtask

  // Two frames with in_valid held; vary=1 scribbles data while busy.
  task automatic b2b(input string tag, input logic [7:0] d0,
                     input logic [7:0] d1, input bit vary);
    i0.in_valid = 1'b1;
    i0.in_data  = d0;
    i0.inj_mask = 5'b0;
    tick();
    for (int c = 0; c < 20; c++) begin
      logic b;
      b = (c < 10) ? fb8(d0, c) : fb8(d1, c - 10);
      check($sformatf("%s lanes c%0d", tag, c), 64'(l0), 64'({5{b}}));
      check($sformatf("%s act c%0d", tag, c), 64'(act0), 64'd1);
      check($sformatf("%s rdy c%0d", tag, c), 64'(i0.in_ready),
            64'(c == 9 || c == 19));
      if (c < 9)  i0.in_data = vary ? (8'hf0 ^ 8'(c)) : d1;
      if (c == 9) i0.in_data = d1;
      if (c >= 10) i0.in_valid = 1'b0;
      tick();
    end
    chk_idle8(tag);
  endtask

  initial begin
    logic [9:0] a5_bits;
    int         n_act;
    a5_bits = 10'b0101001011;

    rst_n = 1'b0;
    i0.in_valid = 1'b0; i0.in_data = '0; i0.inj_mask = '0;
    i1.in_valid = 1'b0; i1.in_data = '0; i1.inj_mask = '0;
    i2.in_valid = 1'b0; i2.in_data = '0; i2.inj_mask = '0;
    tick();
    tick();
    check("rst lanes", 64'(l0), 64'h1f);
    check("rst rdy", 64'(i0.in_ready), 64'd0);
    check("rst act", 64'(act0), 64'd0);
    check("rst last", 64'(last0), 64'd0);
    check("rst w1 lanes", 64'(l1), 64'h0);
    check("rst w32 lanes", 64'(l2), 64'h0);
    rst_n = 1'b1;
    tick();
    check("post rst rdy", 64'(i0.in_ready), 64'd1);
    chk_idle8("post rst");

    // single word 0xA5 against the hand-derived bit sequence
    send8(8'ha5, 5'b0);
    for (int c = 0; c < 10; c++) begin
      chk8("a5", c, a5_bits[9-c], 5'b0);
      tick();
    end
    chk_idle8("a5");

    b2b("b2b", 8'h00, 8'hff, 1'b0);

    // injection on pa and pc; mask input changes mid-frame
    send8(8'h3c, 5'b00101);
    for (int c = 0; c < 10; c++) begin
      chk8("inj", c, fb8(8'h3c, c), 5'b00101);
      if (c == 3) i0.inj_mask = 5'b11010;
      tick();
    end
    i0.inj_mask = 5'b0;
    chk_idle8("inj");

    b2b("bp", 8'h12, 8'h6b, 1'b1);

    // reset at data bit 4 of 0x81
    send8(8'h81, 5'b0);
    repeat (4) tick();
    check("mr pre lanes", 64'(l0), 64'({5{fb8(8'h81, 4)}}));
    rst_n = 1'b0;
    #1;
    check("mr lanes", 64'(l0), 64'h1f);
    check("mr act", 64'(act0), 64'd0);
    check("mr rdy", 64'(i0.in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle8("mr rel");
    send8(8'h81, 5'b0);
    for (int c = 0; c < 10; c++) begin
      chk8("mr", c, fb8(8'h81, c), 5'b0);
      tick();
    end
    chk_idle8("mr");

    // WIDTH=1, idle low: start 1, data 1, stop 0
    i1.in_valid = 1'b1;
    i1.in_data  = 1'b1;
    tick();
    i1.in_valid = 1'b0;
    n_act = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) check("w1 start", 64'(l1), 64'h1f);
      if (c == 1) check("w1 data", 64'(l1), 64'h1f);
      if (c == 2) check("w1 stop", 64'(l1), 64'h0);
      if (c == 2) check("w1 last", 64'(last1), 64'd1);
      if (c >= 3) check("w1 idle", 64'(l1), 64'h0);
      if (act1) n_act++;
      tick();
    end
    check("w1 len", 64'(n_act), 64'd3);

    // WIDTH=32, idle low
    i2.in_valid = 1'b1;
    i2.in_data  = 32'hdeadbeef;
    tick();
    i2.in_valid = 1'b0;
    n_act = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 34)
        check($sformatf("w32 lanes c%0d", c), 64'(l2),
              64'({5{fb32(32'hdeadbeef, c)}}));
      else
        check($sformatf("w32 idle c%0d", c), 64'(l2), 64'h0);
      if (c == 33) check("w32 last", 64'(last2), 64'd1);
      if (act2) n_act++;
      tick();
    end
    check("w32 len", 64'(n_act), 64'd34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rep5_tx.md
REP5_TX -- requirements
Module: rep5_tx

Interface
REQ-001 SHALL expose parameter WIDTH, default 8: data bits per frame (legal 1..32).
REQ-002 SHALL expose parameter IDLE_LEVEL, default 1: lane level driven when no frame is in flight.
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: word offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept a word this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: word to transmit.
REQ-008 SHALL have port inj_mask, input, 5: per-lane inversion for fault injection, bit0=pa .. bit4=pe.
REQ-009 SHALL have ports pa, pb, pc, pd, pe, output, 1 each: five redundant serial lanes for a 5-way majority receiver.
REQ-010 SHALL have port tx_active, output, 1: a frame is on the lanes this cycle.
REQ-011 SHALL have port tx_last, output, 1: stop bit is on the lanes this cycle.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP; the state register is the only source of in_ready, tx_active, tx_last.
REQ-013 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1; in_data and inj_mask are captured on that edge.
REQ-014 SHALL drive in_ready=1 in IDLE and STOP, 0 in START and DATA.
REQ-015 SHALL frame each word as: 1 start bit (~IDLE_LEVEL), WIDTH data bits MSB-first, 1 stop bit (IDLE_LEVEL); frame length WIDTH+2 cycles.
REQ-016 SHALL, on accept edge E, present the start bit from E to E+1, data bit WIDTH-1-i from E+1+i, stop bit from E+WIDTH+1 (zero-cycle latency from accept to start bit).
REQ-017 SHALL transition IDLE->START on accept; START->DATA unconditionally; DATA->STOP after the WIDTH-th data bit, tracked by a bit counter of ceil(log2(WIDTH+1)) bits; STOP->START on accept, else STOP->IDLE.
REQ-018 SHALL support back-to-back frames with no idle gap: accept during STOP yields a frame period of exactly WIDTH+2 cycles.
REQ-019 SHALL drive every lane from a register: lane k = frame_bit XOR captured inj_mask[k] during START, DATA, STOP; lane k = IDLE_LEVEL in IDLE (mask ignored).
REQ-020 SHALL hold captured inj_mask for the whole frame; changes to inj_mask input mid-frame have no effect.
REQ-021 SHALL ignore in_data/in_valid while in_ready=0; no word is dropped or duplicated.
REQ-022 SHALL drive tx_active=1 in START, DATA, STOP; tx_last=1 only in STOP.
REQ-023 SHALL guarantee that with at most two inj_mask bits set, majority of (pa..pe) every cycle equals the unmasked frame bit.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state IDLE, bit counter 0, shift register 0, captured mask 0, pa..pe=IDLE_LEVEL, in_ready=0, tx_active=0, tx_last=0.
REQ-025 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts.
REQ-026 SHALL abort a frame on reset assertion mid-frame with no resumption; the first post-reset accept starts a fresh frame.

Verification
REQ-027 Single word: WIDTH=8, in_data=0xA5, inj_mask=0 -> lanes all equal 0,1,0,1,0,0,1,0,1,1 over 10 cycles; tx_last only on cycle 10; then IDLE_LEVEL.
REQ-028 Back-to-back: in_valid held with 0x00 then 0xFF -> 20 contiguous tx_active cycles, second start bit directly follows first stop bit; in_ready high exactly on stop cycles.
REQ-029 Injection: 0x3C with inj_mask=5'b00101 -> pa, pc inverted every frame cycle, pb/pd/pe correct, majority equals 0x3C frame; changing inj_mask mid-frame has no effect.
REQ-030 Backpressure: in_valid=1 with changing in_data during DATA -> no capture; only value present in the STOP cycle is sent next.
REQ-031 Mid-frame reset: rst_n low at data bit 4 of 0x81 -> lanes IDLE_LEVEL immediately, tx_active=0; after release, 0x81 resent in full.
REQ-032 Parameter sweep: WIDTH=1 and WIDTH=32, IDLE_LEVEL=0 -> frame lengths 3 and 34, start bit 1, stop bit 0, idle 0.
